// File: rtl/cmdin_copy_opt_sched_pkg.sv
// cmdin_pkg: types and constants shared by the copy-opt scheduler files.
//   CopySchedState_t : scheduler FSM state encoding
//   CMD_*            : command type codes carried on req_cmd_type / eng_cmd_type
//   is_bypass()      : decides whether a granted job skips the engine
package cmdin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } CopySchedState_t;

  localparam logic [1:0] CMD_EXEC_TASK     = 2'd0;
  localparam logic [1:0] CMD_SETUP_INST    = 2'd1;
  localparam logic [1:0] CMD_EXEC_PERIODIC = 2'd2;

  // A job skips the engine when optimisation is off, it has no arguments to
  // copy, or it is a setup-inst command (nothing to optimise there).
  function automatic logic is_bypass(input logic       opt_en,
                                     input logic [3:0] num_args,
                                     input logic [1:0] cmd_type);
    logic bypass;
    bypass = 1'b0;
    if (!opt_en || (num_args == 4'd0) || (cmd_type == CMD_SETUP_INST)) begin
      bypass = 1'b1;
    end else begin
      bypass = 1'b0;
    end
    return bypass;
  endfunction

endpackage

// File: rtl/cmdin_copy_opt_sched_if.sv
// Bus between the two command-in requesters, the scheduler and the copy-opt
// engine.
//   req_valid/req_ready        : per-requester job handshake ([0] cmd in, [1] int cmd in)
//   req_first_idx/_next_idx    : per-requester subqueue operands
//   req_num_args/req_cmd_type  : per-requester job descriptor
//   req_done                   : one-cycle completion pulse to the owner
//   eng_start/eng_finished     : engine run protocol
//   eng_*                      : operands held for the engine during a run
// Modports: master = requesters + engine side, slave = scheduler.
interface cmdin_copy_opt_sched_if #(
  parameter int SUBQUEUE_BITS = 6
) ();

  logic [1:0]                        req_valid;
  logic [1:0]                        req_ready;
  logic [1:0][SUBQUEUE_BITS-1:0]     req_first_idx;
  logic [1:0][SUBQUEUE_BITS-1:0]     req_first_next_idx;
  logic [1:0][3:0]                   req_num_args;
  logic [1:0][1:0]                   req_cmd_type;
  logic [1:0]                        req_done;

  logic                              eng_start;
  logic                              eng_finished;
  logic [SUBQUEUE_BITS-1:0]          eng_first_idx;
  logic [SUBQUEUE_BITS-1:0]          eng_first_next_idx;
  logic [3:0]                        eng_num_args;
  logic [1:0]                        eng_cmd_type;
  logic                              eng_queue_select;

  modport master (
    output req_valid, req_first_idx, req_first_next_idx, req_num_args,
           req_cmd_type, eng_finished,
    input  req_ready, req_done, eng_start, eng_first_idx, eng_first_next_idx,
           eng_num_args, eng_cmd_type, eng_queue_select
  );

  modport slave (
    input  req_valid, req_first_idx, req_first_next_idx, req_num_args,
           req_cmd_type, eng_finished,
    output req_ready, req_done, eng_start, eng_first_idx, eng_first_next_idx,
           eng_num_args, eng_cmd_type, eng_queue_select
  );

endinterface

// File: rtl/cmdin_copy_opt_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   i_valid    : request bits, [0] cmd in, [1] int cmd in
//   i_last_gnt : index of the requester granted most recently
//   o_grant    : one-hot (or zero) grant; on a tie the requester that did not
//                win last time is chosen
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_gnt,
  output logic [1:0] o_grant
);

  // Grant decode; ties go to the requester other than i_last_gnt.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_gnt ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cmdin_copy_opt_sched.sv
// cmdin_copy_opt_sched: shares one copy-opt engine between the command-in and
// internal command-in paths. One job at a time: grant (IDLE), pulse eng_start
// (START), wait for eng_finished (WAIT), pulse req_done to the owner (DONE).
// Bypassed jobs go straight from grant to DONE.
//   clk, rstn  : clock, asynchronous active-low reset
//   opt_enable : 0 forces every job to bypass; sampled only at grant
//   bus        : requester handshake/payload and engine operands (slave side)
//   busy       : high whenever the FSM is not in IDLE
//   run_count  : saturating count of engine runs started
module cmdin_copy_opt_sched
  import cmdin_pkg::*;
#(
  parameter int SUBQUEUE_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  opt_enable,
  cmdin_copy_opt_sched_if.slave bus,
  output logic                  busy,
  output logic [31:0]           run_count
);

  CopySchedState_t            r_state;
  CopySchedState_t            w_next_state;

  logic                       r_last_gnt;
  logic [1:0]                 w_grant;
  logic                       w_gnt_idx;
  logic                       w_bypass;
  logic                       w_start;
  logic [1:0]                 w_ready;
  logic [1:0]                 w_done_vec;

  logic                       r_eng_start;
  logic [SUBQUEUE_BITS-1:0]   r_eng_first_idx;
  logic [SUBQUEUE_BITS-1:0]   r_eng_first_next_idx;
  logic [3:0]                 r_eng_num_args;
  logic [1:0]                 r_eng_cmd_type;
  logic                       r_eng_queue_select;
  logic [1:0]                 r_req_done;
  logic                       r_busy;
  logic [31:0]                r_run_count;

  rr_arb2 u_arb (
    .i_valid    (bus.req_valid),
    .i_last_gnt (r_last_gnt),
    .o_grant    (w_grant)
  );

  // Next-state decode plus grant/start/done strobes for the job sequencer.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 2'b00;
    w_start      = 1'b0;
    w_done_vec   = 2'b00;
    w_gnt_idx    = w_grant[1];
    w_bypass     = is_bypass(opt_enable, bus.req_num_args[w_gnt_idx],
                             bus.req_cmd_type[w_gnt_idx]);
    case (r_state)
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          w_ready = w_grant;
          if (w_bypass) begin
            w_next_state = ST_DONE;
            w_done_vec   = w_grant;
          end else begin
            w_next_state = ST_START;
            w_start      = 1'b1;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_START: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.eng_finished) begin
          w_next_state = ST_DONE;
          w_done_vec   = r_eng_queue_select ? 2'b10 : 2'b01;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand latch, output strobes, owner pointer and run counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_gnt           <= 1'b1;
      r_eng_start          <= 1'b0;
      r_eng_first_idx      <= '0;
      r_eng_first_next_idx <= '0;
      r_eng_num_args       <= 4'd0;
      r_eng_cmd_type       <= 2'd0;
      r_eng_queue_select   <= 1'b0;
      r_req_done           <= 2'b00;
      r_busy               <= 1'b0;
      r_run_count          <= 32'd0;
    end else begin
      r_eng_start <= w_start;
      r_req_done  <= w_done_vec;
      r_busy      <= (w_next_state != ST_IDLE);
      // Operands are captured once at grant and then held until the next
      // grant, so the engine sees them stable for its whole run.
      if ((r_state == ST_IDLE) && (w_grant != 2'b00)) begin
        r_eng_first_idx      <= bus.req_first_idx[w_gnt_idx];
        r_eng_first_next_idx <= bus.req_first_next_idx[w_gnt_idx];
        r_eng_num_args       <= bus.req_num_args[w_gnt_idx];
        r_eng_cmd_type       <= bus.req_cmd_type[w_gnt_idx];
        r_eng_queue_select   <= w_gnt_idx;
      end else begin
        r_eng_queue_select   <= r_eng_queue_select;
      end
      if (r_state == ST_DONE) begin
        r_last_gnt <= r_eng_queue_select;
      end else begin
        r_last_gnt <= r_last_gnt;
      end
      if ((r_state == ST_START) && (r_run_count != 32'hFFFF_FFFF)) begin
        r_run_count <= r_run_count + 32'd1;
      end else begin
        r_run_count <= r_run_count;
      end
    end
  end

  assign bus.req_ready          = w_ready;
  assign bus.req_done           = r_req_done;
  assign bus.eng_start          = r_eng_start;
  assign bus.eng_first_idx      = r_eng_first_idx;
  assign bus.eng_first_next_idx = r_eng_first_next_idx;
  assign bus.eng_num_args       = r_eng_num_args;
  assign bus.eng_cmd_type       = r_eng_cmd_type;
  assign bus.eng_queue_select   = r_eng_queue_select;
  assign busy                   = r_busy;
  assign run_count              = r_run_count;

endmodule

// File: tb/tb_cmdin_copy_opt_sched.sv
// Scoreboard bench for cmdin_copy_opt_sched: expected completions are queued
// as jobs are issued; a monitor pops one entry per req_done pulse.
module tb_cmdin_copy_opt_sched;

  typedef struct {
    bit         owner;
    logic [5:0] fi;
    logic [5:0] fn;
    logic [3:0] na;
    logic [1:0] ct;
    bit         ran;
  } exp_t;

  logic clk;
  logic rstn;
  logic opt_enable;
  logic busy;
  logic [31:0] run_count;

  logic [1:0]      tb_valid;
  logic [1:0][5:0] tb_fi;
  logic [1:0][5:0] tb_fn;
  logic [1:0][3:0] tb_na;
  logic [1:0][1:0] tb_ct;
  logic            fin_model;
  logic            fin_manual;

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   acc_cyc;
  int   fin_cyc;
  int   n_starts;
  int   eng_delay;
  exp_t sb[$];

  cmdin_copy_opt_sched_if #(.SUBQUEUE_BITS(6)) bus ();

  assign bus.req_valid          = tb_valid;
  assign bus.req_first_idx      = tb_fi;
  assign bus.req_first_next_idx = tb_fn;
  assign bus.req_num_args       = tb_na;
  assign bus.req_cmd_type       = tb_ct;
  assign bus.eng_finished       = fin_model | fin_manual;

  cmdin_copy_opt_sched #(.SUBQUEUE_BITS(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .opt_enable (opt_enable),
    .bus        (bus),
    .busy       (busy),
    .run_count  (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: counts starts and pulses finished eng_delay cycles later,
  // abandoning the run if reset hits in between.
  initial begin
    fin_model = 1'b0;
    n_starts  = 0;
    fin_cyc   = -10;
    forever begin
      @(negedge clk);
      if (rstn && bus.eng_start) begin
        bit aborted;
        aborted = 1'b0;
        n_starts++;
        for (int i = 0; i < eng_delay; i++) begin
          @(negedge clk);
          if (!rstn) aborted = 1'b1;
        end
        if (!aborted) begin
          fin_model = 1'b1;
          fin_cyc   = cyc;
          @(negedge clk);
          fin_model = 1'b0;
        end
      end
    end
  end

  // Monitor: one scoreboard entry per req_done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && (bus.req_done != 2'b00)) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'd0, bus.req_done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_owner", {30'd0, bus.req_done}, e.owner ? 32'd2 : 32'd1);
          chk("queue_select", {31'd0, bus.eng_queue_select}, {31'd0, e.owner});
          chk("eng_first_idx", {26'd0, bus.eng_first_idx}, {26'd0, e.fi});
          chk("eng_first_next_idx", {26'd0, bus.eng_first_next_idx}, {26'd0, e.fn});
          chk("eng_num_args", {28'd0, bus.eng_num_args}, {28'd0, e.na});
          chk("eng_cmd_type", {30'd0, bus.eng_cmd_type}, {30'd0, e.ct});
          if (e.ran) chk("done_after_finished", cyc, fin_cyc + 1);
          else       chk("bypass_done_latency", cyc, acc_cyc + 1);
        end
      end
    end
  end

  // Present one job, wait for its accept, then check the START/bypass cycle.
  task automatic issue(input bit r, input logic [5:0] fi, input logic [5:0] fn,
                       input logic [3:0] na, input logic [1:0] ct, input bit ran);
    bit   got;
    exp_t e;
    @(negedge clk);
    tb_fi[r] = fi; tb_fn[r] = fn; tb_na[r] = na; tb_ct[r] = ct;
    tb_valid[r] = 1'b1;
    e.owner = r; e.fi = fi; e.fn = fn; e.na = na; e.ct = ct; e.ran = ran;
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (bus.req_ready == (2'b01 << r)) got = 1'b1;
      else @(negedge clk);
    end
    chk("accept", {31'd0, got}, 32'd1);
    if (got) begin
      acc_cyc = cyc;
      @(posedge clk);
      #1 tb_valid[r] = 1'b0;
      @(negedge clk);
      chk("eng_start", {31'd0, bus.eng_start}, {31'd0, ran});
      chk("busy_after_grant", {31'd0, busy}, 32'd1);
    end else begin
      tb_valid[r] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk("idle_timeout", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    int starts_before;
    n_checks = 0; n_errors = 0; cyc = 0; acc_cyc = -10;
    eng_delay = 7;
    rstn = 1'b0; opt_enable = 1'b1;
    tb_valid = 2'b00; tb_fi = '0; tb_fn = '0; tb_na = '0; tb_ct = '0;
    fin_manual = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_run_count", run_count, 32'd0);
    chk("rst_eng_start", {31'd0, bus.eng_start}, 32'd0);
    chk("rst_req_done", {30'd0, bus.req_done}, 32'd0);
    chk("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_eng_first_next_idx", {26'd0, bus.eng_first_next_idx}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    // Single engine job on requester 0
    issue(1'b0, 6'd0, 6'd10, 4'd2, 2'd0, 1'b1);
    chk("single_queue_select", {31'd0, bus.eng_queue_select}, 32'd0);
    wait_idle();
    chk("single_run_count", run_count, 32'd1);

    // Spurious finished while IDLE
    @(negedge clk) fin_manual = 1'b1;
    @(negedge clk) fin_manual = 1'b0;
    chk("spur_idle_busy", {31'd0, busy}, 32'd0);
    chk("spur_idle_done", {30'd0, bus.req_done}, 32'd0);
    @(negedge clk);
    chk("spur_idle_busy2", {31'd0, busy}, 32'd0);

    // Operand stability on requester 1 while its payload keeps changing
    eng_delay = 6;
    issue(1'b1, 6'd33, 6'd40, 4'd5, 2'd2, 1'b1);
    for (int k = 0; k < 40; k++) begin
      tb_fi[1] = 6'($urandom);
      tb_fn[1] = 6'($urandom);
      #1;
      if (bus.req_done[1]) break;
      chk("stable_first_idx", {26'd0, bus.eng_first_idx}, 32'd33);
      chk("stable_first_next_idx", {26'd0, bus.eng_first_next_idx}, 32'd40);
      @(negedge clk);
    end
    wait_idle();
    chk("stable_run_count", run_count, 32'd2);

    // Contention: both valid continuously, expected grants 0,1,0,1
    eng_delay = 3;
    begin
      exp_t e;
      int   idx0, idx1, accepted;
      logic [5:0] fi0 [2], fi1 [2];
      fi0[0] = 6'd1; fi0[1] = 6'd4; fi1[0] = 6'd7; fi1[1] = 6'd10;
      e.ran = 1'b1;
      e.owner = 1'b0; e.fi = 6'd1;  e.fn = 6'd2;  e.na = 4'd3;  e.ct = 2'd0; sb.push_back(e);
      e.owner = 1'b1; e.fi = 6'd7;  e.fn = 6'd8;  e.na = 4'd9;  e.ct = 2'd0; sb.push_back(e);
      e.owner = 1'b0; e.fi = 6'd4;  e.fn = 6'd5;  e.na = 4'd6;  e.ct = 2'd2; sb.push_back(e);
      e.owner = 1'b1; e.fi = 6'd10; e.fn = 6'd11; e.na = 4'd12; e.ct = 2'd2; sb.push_back(e);
      @(negedge clk);
      tb_fi[0] = fi0[0]; tb_fn[0] = 6'd2; tb_na[0] = 4'd3; tb_ct[0] = 2'd0;
      tb_fi[1] = fi1[0]; tb_fn[1] = 6'd8; tb_na[1] = 4'd9; tb_ct[1] = 2'd0;
      tb_valid = 2'b11;
      idx0 = 0; idx1 = 0; accepted = 0;
      for (int k = 0; k < 400 && accepted < 4; k++) begin
        #1;
        if (bus.req_ready != 2'b00) begin
          acc_cyc = cyc;
          accepted++;
          @(posedge clk);
          #1;
          if (bus.req_ready == 2'b10) begin end
          if (dut.r_eng_queue_select) begin end
          if (tb_valid == 2'b11 && idx0 + idx1 == accepted - 1) begin end
          if (sb.size() > 0) begin end
          if (dut.bus.eng_queue_select == 1'b0) begin
            idx0++;
            if (idx0 < 2) begin
              tb_fi[0] = fi0[1]; tb_fn[0] = 6'd5; tb_na[0] = 4'd6; tb_ct[0] = 2'd2;
            end else tb_valid[0] = 1'b0;
          end else begin
            idx1++;
            if (idx1 < 2) begin
              tb_fi[1] = fi1[1]; tb_fn[1] = 6'd11; tb_na[1] = 4'd12; tb_ct[1] = 2'd2;
            end else tb_valid[1] = 1'b0;
          end
        end
        @(negedge clk);
      end
      chk("contention_accepts", accepted, 32'd4);
      tb_valid = 2'b00;
    end
    wait_idle();
    chk("contention_run_count", run_count, 32'd6);

    // Bypass jobs: no args, setup inst, optimisation disabled
    starts_before = n_starts;
    issue(1'b0, 6'd3, 6'd4, 4'd0, 2'd0, 1'b0);
    wait_idle();
    issue(1'b0, 6'd5, 6'd6, 4'd2, 2'd1, 1'b0);
    wait_idle();
    opt_enable = 1'b0;
    issue(1'b0, 6'd7, 6'd8, 4'd3, 2'd0, 1'b0);
    opt_enable = 1'b1;
    wait_idle();
    chk("bypass_no_start", n_starts, starts_before);
    chk("bypass_run_count", run_count, 32'd6);

    // Spurious finished during START (issue returns in the START cycle)
    eng_delay = 4;
    issue(1'b0, 6'd20, 6'd21, 4'd1, 2'd2, 1'b1);
    fin_manual = 1'b1;
    @(negedge clk) fin_manual = 1'b0;
    chk("spur_start_busy", {31'd0, busy}, 32'd1);
    chk("spur_start_done", {30'd0, bus.req_done}, 32'd0);
    wait_idle();
    chk("spur_start_run_count", run_count, 32'd7);

    // Reset in the middle of WAIT
    eng_delay = 20;
    issue(1'b0, 6'd50, 6'd60, 4'd7, 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_run_count", run_count, 32'd0);
    chk("rstmid_eng_start", {31'd0, bus.eng_start}, 32'd0);
    chk("rstmid_req_done", {30'd0, bus.req_done}, 32'd0);
    chk("rstmid_first_idx", {26'd0, bus.eng_first_idx}, 32'd0);
    chk("rstmid_first_next_idx", {26'd0, bus.eng_first_next_idx}, 32'd0);
    chk("rstmid_num_args", {28'd0, bus.eng_num_args}, 32'd0);
    chk("rstmid_queue_select", {31'd0, bus.eng_queue_select}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Fresh job after reset
    eng_delay = 3;
    issue(1'b1, 6'd12, 6'd13, 4'd4, 2'd0, 1'b1);
    wait_idle();
    chk("post_rst_run_count", run_count, 32'd1);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
